// File: rtl/orlink_chan_engine.sv
// FX2 slave-FIFO command engine routing bytes to NUM_CHAN byte streams; ORLINK_PKTEND_EN adds a PKTEND commit after reads.
// Latency: data phase opens 5 cycles after the command byte; byte strobes are combinational.
// Backpressure: slrd/slwr held high while the selected channel or the FX2 FIFO cannot move a byte.
module orlink_chan_engine #(
   parameter int NUM_CHAN = 8,
   parameter int CNT_W    = 32
) (
   input  logic                  wb_clk,
   input  logic                  wb_rst_n,
   input  logic [7:0]            fifoData_in,
   output logic [7:0]            fifoData_out,
   output logic                  fifoData_oe,
   input  logic                  gotData_in,
   input  logic                  gotRoom_in,
   output logic                  sloe_out,
   output logic                  slrd_out,
   output logic                  slwr_out,
   output logic [1:0]            fifoAddr_out,
   output logic                  pktEnd_out,
   output logic [7:0]            h2f_data,
   output logic [NUM_CHAN-1:0]   h2f_valid,
   input  logic [NUM_CHAN-1:0]   h2f_ready,
   input  logic [8*NUM_CHAN-1:0] f2h_data,
   input  logic [NUM_CHAN-1:0]   f2h_valid,
   output logic [NUM_CHAN-1:0]   f2h_ready,
   output logic                  busy,
   output logic                  err
);
   typedef enum logic [2:0] {
      S_IDLE, S_CNT, S_WDATA, S_TURN, S_RDATA
`ifdef ORLINK_PKTEND_EN
      , S_PKTEND
`endif
   } state_t;

   localparam logic [7:0] NCH = 8'(NUM_CHAN);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_run;
   logic [6:0]          r_chan;
   logic                r_dir;
   logic [1:0]          r_idx;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_err;
   logic [NUM_CHAN-1:0] w_sel;
   logic [7:0]          w_f2h_dat;
   logic                w_chan_ok;
   logic                w_h2f_rdy;
   logic                w_f2h_vld;
   logic                w_rd;
   logic                w_wr;
   logic                w_drop;
   logic [CNT_W-1:0]    w_cnt_sh;

   always_comb begin
      w_sel     = '0;
      w_f2h_dat = 8'h00;
      for (int k = 0; k < NUM_CHAN; k++) begin
         if (r_chan == 7'(k)) begin
            w_sel[k]  = 1'b1;
            w_f2h_dat = f2h_data[8*k +: 8];
         end
      end
   end

   // An out-of-range channel acts as an always-ready sink and an always-valid zero source.
   assign w_chan_ok = {1'b0, r_chan} < NCH;
   assign w_h2f_rdy = w_chan_ok ? |(h2f_ready & w_sel) : 1'b1;
   assign w_f2h_vld = w_chan_ok ? |(f2h_valid & w_sel) : 1'b1;

   // Count bytes arrive MSB first; bits above CNT_W are dropped but flagged if set.
   always_comb begin
      w_drop = 1'b0;
      for (int j = 0; j < 8; j++) begin
         if (fifoData_in[j] && ((3 - int'(r_idx)) * 8 + j >= CNT_W)) w_drop = 1'b1;
      end
   end
   assign w_cnt_sh = CNT_W'({r_cnt, fifoData_in});

   assign h2f_data = fifoData_in;
   assign busy     = (r_state != S_IDLE);
   assign err      = r_err;

   always_comb begin
      w_state_nxt  = r_state;
      w_rd         = 1'b0;
      w_wr         = 1'b0;
      sloe_out     = 1'b1;
      slrd_out     = 1'b1;
      slwr_out     = 1'b1;
      pktEnd_out   = 1'b1;
      fifoAddr_out = 2'b00;
      fifoData_oe  = 1'b0;
      fifoData_out = 8'h00;
      h2f_valid    = '0;
      f2h_ready    = '0;
      case (r_state)
         S_IDLE: begin
            if (r_run) begin
               sloe_out = 1'b0;
               w_rd     = gotData_in;
               slrd_out = !w_rd;
               if (w_rd) w_state_nxt = S_CNT;
            end
         end
         S_CNT: begin
            sloe_out = 1'b0;
            w_rd     = gotData_in;
            slrd_out = !w_rd;
            if (w_rd && r_idx == 2'd3) begin
               if (w_cnt_sh == '0) w_state_nxt = S_IDLE;
               else                w_state_nxt = r_dir ? S_TURN : S_WDATA;
            end
         end
         S_WDATA: begin
            sloe_out  = 1'b0;
            w_rd      = gotData_in & w_h2f_rdy;
            slrd_out  = !w_rd;
            h2f_valid = w_sel & h2f_ready & {NUM_CHAN{gotData_in}};
            if (w_rd && r_cnt == CNT_W'(1)) w_state_nxt = S_IDLE;
         end
         S_TURN: begin
            fifoAddr_out = 2'b10;
            fifoData_oe  = 1'b1;
            w_state_nxt  = S_RDATA;
         end
         S_RDATA: begin
            fifoAddr_out = 2'b10;
            fifoData_oe  = 1'b1;
            fifoData_out = w_f2h_dat;
            w_wr         = gotRoom_in & w_f2h_vld;
            slwr_out     = !w_wr;
            f2h_ready    = w_sel & {NUM_CHAN{w_wr}};
            if (w_wr && r_cnt == CNT_W'(1)) begin
`ifdef ORLINK_PKTEND_EN
               w_state_nxt = S_PKTEND;
`else
               w_state_nxt = S_IDLE;
`endif
            end
         end
`ifdef ORLINK_PKTEND_EN
         S_PKTEND: begin
            fifoAddr_out = 2'b10;
            if (gotRoom_in) begin
               pktEnd_out  = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_state <= S_IDLE;
         r_run   <= 1'b0;
         r_chan  <= '0;
         r_dir   <= 1'b0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= 1'b1;
         if (r_state == S_IDLE && w_rd) begin
            r_chan <= fifoData_in[6:0];
            r_dir  <= fifoData_in[7];
            r_idx  <= '0;
            if ({1'b0, fifoData_in[6:0]} >= NCH) r_err <= 1'b1;
         end
         if (r_state == S_CNT && w_rd) begin
            r_cnt <= w_cnt_sh;
            r_idx <= r_idx + 2'd1;
            if (w_drop) r_err <= 1'b1;
         end
         if ((r_state == S_WDATA && w_rd) || w_wr) r_cnt <= r_cnt - CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_orlink_chan_engine.sv
// Bench for orlink_chan_engine: host FX2 stream and channel endpoints modelled with queues.
module tb_orlink_chan_engine;
   localparam int NC = 8;
`ifdef ORLINK_PKTEND_EN
   localparam bit PKT = 1'b1;
`else
   localparam bit PKT = 1'b0;
`endif

   logic            wb_clk, wb_rst_n;
   logic [7:0]      fifoData_in, fifoData_out;
   logic            fifoData_oe, gotData_in, gotRoom_in;
   logic            sloe_out, slrd_out, slwr_out, pktEnd_out;
   logic [1:0]      fifoAddr_out;
   logic [7:0]      h2f_data;
   logic [NC-1:0]   h2f_valid, h2f_ready, f2h_valid, f2h_ready;
   logic [8*NC-1:0] f2h_data;
   logic            busy, err;

   orlink_chan_engine #(.NUM_CHAN(NC), .CNT_W(32)) dut (
      .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
      .fifoData_in(fifoData_in), .fifoData_out(fifoData_out), .fifoData_oe(fifoData_oe),
      .gotData_in(gotData_in), .gotRoom_in(gotRoom_in),
      .sloe_out(sloe_out), .slrd_out(slrd_out), .slwr_out(slwr_out),
      .fifoAddr_out(fifoAddr_out), .pktEnd_out(pktEnd_out),
      .h2f_data(h2f_data), .h2f_valid(h2f_valid), .h2f_ready(h2f_ready),
      .f2h_data(f2h_data), .f2h_valid(f2h_valid), .f2h_ready(f2h_ready),
      .busy(busy), .err(err)
   );

   initial wb_clk = 1'b0;
   always #5 wb_clk = ~wb_clk;

   int tests = 0, fails = 0, cyc = 0;
   byte unsigned hq[$], src_q[$], pay[$], got_h2f[$], got_dev[$];
   int got_ch[$], cons_cyc[$];
   int src_ch = 0, n_frdy = 0, n_pkt = 0, room_mode = 0, stall_ch = 0, stall_left = 0;
   bit fast = 1'b0, exp_err = 1'b0, stall_arm = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check($sformatf("%s_ctl", tag),
            64'({sloe_out, slrd_out, slwr_out, pktEnd_out, fifoAddr_out, fifoData_oe, fifoData_out, busy, err}),
            64'({4'hF, 2'b00, 1'b0, 8'h00, 2'b00}));
      check($sformatf("%s_strb", tag), 64'({h2f_valid, f2h_ready}), 64'd0);
   endtask

   // FX2 and channel stimulus for the coming clock edge.
   task automatic drive();
      gotData_in  = (hq.size() > 0) && (fast || $urandom_range(3) != 0);
      fifoData_in = (hq.size() > 0) ? hq[0] : 8'($urandom);
      case (room_mode)
         1:       gotRoom_in = cyc[0];
         2:       gotRoom_in = 1'b1;
         default: gotRoom_in = ($urandom_range(2) != 0);
      endcase
      for (int k = 0; k < NC; k++) begin
         h2f_ready[k]       = fast || ($urandom_range(2) != 0);
         f2h_valid[k]       = ($urandom_range(1) == 1);
         f2h_data[8*k +: 8] = 8'($urandom);
      end
      if (stall_left > 0) h2f_ready[stall_ch] = 1'b0;
      f2h_valid[src_ch] = (src_q.size() > 0) && (fast || $urandom_range(3) != 0);
      if (src_q.size() > 0) f2h_data[8*src_ch +: 8] = src_q[0];
   endtask

   // Observe the transfers that the coming edge will perform.
   task automatic sample();
      bit ok;
      ok = 1'b1;
      if (!slrd_out && !slwr_out) ok = 1'b0;
      if (!$onehot0(h2f_valid) || !$onehot0(f2h_ready)) ok = 1'b0;
      if ((h2f_valid & ~h2f_ready) != '0) ok = 1'b0;
      if (h2f_valid != '0 && (slrd_out || !gotData_in)) ok = 1'b0;
      if (f2h_ready != '0 && slwr_out) ok = 1'b0;
      if ((f2h_ready & ~f2h_valid) != '0) ok = 1'b0;
      if (!slwr_out && (!gotRoom_in || !fifoData_oe || fifoAddr_out != 2'b10)) ok = 1'b0;
      if (!slrd_out && (fifoData_oe || fifoAddr_out != 2'b00 || sloe_out)) ok = 1'b0;
      check("invariant", 64'(ok), 64'd1);
      if (stall_left > 0) begin
         if (gotData_in) check("stall_slrd", 64'(slrd_out), 64'd1);
         stall_left--;
      end
      if (!slrd_out && gotData_in) begin
         cons_cyc.push_back(cyc);
         if (hq.size() > 0) void'(hq.pop_front());
      end
      for (int k = 0; k < NC; k++) begin
         if (h2f_valid[k]) begin
            got_ch.push_back(k);
            got_h2f.push_back(h2f_data);
            if (stall_arm && k == stall_ch) begin
               stall_arm  = 1'b0;
               stall_left = 3;
            end
         end
      end
      if (!slwr_out) got_dev.push_back(fifoData_out);
      if (f2h_ready != '0) begin
         n_frdy++;
         if (f2h_ready[src_ch] && src_q.size() > 0) void'(src_q.pop_front());
      end
      if (!pktEnd_out) n_pkt++;
   endtask

   task automatic step();
      @(negedge wb_clk);
      sample();
      @(posedge wb_clk);
      #1;
      cyc++;
      drive();
   endtask

   // One command: reference result from the protocol rules, then compare.
   task automatic txn(input string tag, input bit dir, input int ch, input int cnt,
                      input bit fast_i, input int room_i);
      byte unsigned exp_q[$];
      bit vld, ok;
      int budget;
      vld = (ch < NC);
      if (!vld) exp_err = 1'b1;
      fast = fast_i;
      room_mode = room_i;
      got_h2f.delete(); got_ch.delete(); got_dev.delete(); cons_cyc.delete(); src_q.delete();
      n_frdy = 0;
      n_pkt  = 0;
      while (pay.size() < cnt) pay.push_back(8'($urandom));
      hq.push_back({dir, 7'(ch)});
      for (int i = 3; i >= 0; i--) hq.push_back(8'(cnt >> (8*i)));
      if (!dir) begin
         for (int i = 0; i < cnt; i++) hq.push_back(pay[i]);
      end else begin
         src_ch = vld ? ch : 0;
         if (vld) for (int i = 0; i < cnt; i++) src_q.push_back(pay[i]);
      end
      for (int i = 0; i < cnt; i++) exp_q.push_back((dir && !vld) ? 8'h00 : pay[i]);
      pay.delete();
      budget = 0;
      do begin
         step();
         budget++;
      end while ((hq.size() != 0 || busy) && budget < 2000);
      check($sformatf("%s_done", tag), 64'(budget < 2000), 64'd1);
      check($sformatf("%s_err", tag), 64'(err), 64'(exp_err));
      if (!dir) begin
         check($sformatf("%s_h2f_n", tag), 64'(got_h2f.size()), 64'(vld ? cnt : 0));
         ok = 1'b1;
         for (int i = 0; i < got_h2f.size() && i < cnt; i++)
            if (got_h2f[i] != exp_q[i] || got_ch[i] != ch) ok = 1'b0;
         check($sformatf("%s_h2f_dat", tag), 64'(ok), 64'd1);
         check($sformatf("%s_nodev", tag), 64'(got_dev.size() + n_frdy + n_pkt), 64'd0);
      end else begin
         check($sformatf("%s_dev_n", tag), 64'(got_dev.size()), 64'(cnt));
         ok = 1'b1;
         for (int i = 0; i < got_dev.size() && i < cnt; i++)
            if (got_dev[i] != exp_q[i]) ok = 1'b0;
         check($sformatf("%s_dev_dat", tag), 64'(ok), 64'd1);
         check($sformatf("%s_frdy", tag), 64'(n_frdy), 64'(vld ? cnt : 0));
         check($sformatf("%s_pktend", tag), 64'(n_pkt), 64'((PKT && cnt > 0) ? 1 : 0));
         check($sformatf("%s_noh2f", tag), 64'(got_h2f.size()), 64'd0);
      end
      if (cons_cyc.size() >= 6)
         check($sformatf("%s_lat", tag), 64'(cons_cyc[5] - cons_cyc[0] >= 5), 64'd1);
   endtask

   initial begin
      int budget;
      wb_rst_n = 1'b0;
      fifoData_in = 8'h00; gotData_in = 1'b1; gotRoom_in = 1'b1;
      h2f_ready = '0; f2h_valid = '0; f2h_data = '0;
      #12;
      check_reset("por");
      @(negedge wb_clk);
      wb_rst_n = 1'b1;
      @(posedge wb_clk);
      #1;
      cyc++;
      drive();

      pay = {8'h13};
      txn("wr13", 1'b0, 0, 1, 1'b1, 2);
      pay = got_h2f;
      txn("loop", 1'b1, 0, 1, 1'b1, 2);
      check("loop_13", 64'(got_dev[0]), 64'h13);

      pay = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
      stall_ch  = 3;
      stall_arm = 1'b1;
      txn("stall", 1'b0, 3, 4, 1'b1, 2);
      stall_arm = 1'b0;

      txn("cnt0", 1'b1, 5, 0, 1'b1, 2);
      check("cnt0_idle", 64'(cyc - cons_cyc[$]), 64'd1);

      txn("badw", 1'b0, 127, 2, 1'b0, 0);
      txn("badr", 1'b1, 127, 2, 1'b0, 0);
      txn("toggle", 1'b1, 1, 3, 1'b1, 1);

      for (int t = 0; t < 14; t++)
         txn($sformatf("rnd%0d", t), 1'($urandom_range(1)), $urandom_range(9),
             $urandom_range(6), 1'b0, 0);

      // Abort a 5-byte write after two bytes have gone out.
      fast = 1'b1;
      room_mode = 2;
      got_h2f.delete();
      hq = {8'h02, 8'h00, 8'h00, 8'h00, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      budget = 0;
      while (got_h2f.size() < 2 && budget < 200) begin
         step();
         budget++;
      end
      check("rst_mid_reach", 64'(budget < 200), 64'd1);
      #1;
      wb_rst_n   = 1'b0;
      gotData_in = 1'b1;
      #1;
      check_reset("rst_async");
      for (int i = 0; i < 3; i++) begin
         @(negedge wb_clk);
         check_reset("rst_hold");
      end
      hq.delete();
      exp_err  = 1'b0;
      wb_rst_n = 1'b1;
      @(posedge wb_clk);
      #1;
      cyc++;
      drive();
      pay = {8'h5A, 8'hC3, 8'h01};
      txn("post_rst", 1'b0, 2, 3, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
